color_sequencer: RTL and testbench

Consumes the one-cycle `tick` pulse produced by the team's periodic timer and drives the RGB fill color used by the VGA pixel path. It steps through a fixed 8-entry palette, holding each color for a programmable number of ticks. It supports pause and manual step inputs, and optionally cross-fades between colors. The block sits between the timer and the VGA color mux, in the 25.175 MHz pixel-clock domain.

---
 rtl/color_pkg.sv | 22 ++
 rtl/color_fade_channel.sv | 43 ++++
 rtl/color_sequencer.sv | 151 +++++++++++++++
 tb/tb_color_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the color sequencer: RGB struct, fixed palette, FSM states.
package color_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int NUM_COLORS = 8;

  localparam rgb_t PALETTE [0:NUM_COLORS-1] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
    24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h000000
  };

  typedef enum logic {
    DWELL = 1'b0,
    FADE  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/color_fade_channel.sv
// One 8-bit color channel that walks toward a target by at most STEP per enable,
// or jumps straight to it on snap.
module color_fade_channel #(
  parameter logic [7:0] INIT = 8'h00,
  parameter int         STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       snap,
  input  logic [7:0] target,
  output logic [7:0] value,
  output logic       done
);

  localparam logic [7:0] STEP8 = 8'(STEP);

  logic [7:0] value_reg;
  logic [7:0] diff;
  logic [7:0] step_amt;
  logic       rising;

  // Difference is always taken in the non-negative direction, so the step never overshoots.
  always_comb begin
    rising   = (target >= value_reg);
    diff     = rising ? (target - value_reg) : (value_reg - target);
    step_amt = (diff < STEP8) ? diff : STEP8;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= INIT;
    end else if (snap) begin
      value_reg <= target;
    end else if (enable) begin
      value_reg <= rising ? (value_reg + step_amt) : (value_reg - step_amt);
    end
  end

  assign value = value_reg;
  assign done  = (value_reg == target);

endmodule

// File: rtl/color_sequencer.sv
// Steps through the fixed palette on timer ticks, with pause and manual step.
// Define COLOR_FADE_EN to cross-fade between colors instead of switching instantly.
module color_sequencer
  import color_pkg::*;
#(
  parameter int TICKS_PER_COLOR = 3,
  parameter int FADE_STEP       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       step,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [2:0] color_idx,
  output logic       wrap
);

  localparam int CW = (TICKS_PER_COLOR > 1) ? $clog2(TICKS_PER_COLOR) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TICKS_PER_COLOR - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NUM_COLORS - 1);

  if (TICKS_PER_COLOR < 1) begin : g_bad_ticks
    $error("TICKS_PER_COLOR must be at least 1");
  end
  if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_step
    $error("FADE_STEP must be in 1..255");
  end

  logic          eff_tick;
  logic          dwell_adv;
  logic          advance;
  logic          count_en;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic          wrap_reg, wrap_next;

  assign eff_tick  = tick & ~pause;
  // step and a terminal tick in the same cycle still produce a single advance.
  assign dwell_adv = step | (eff_tick & (cnt_reg == LAST_CNT));

`ifdef COLOR_FADE_EN
  seq_state_t state_reg, state_next;
  logic       fade_en;
  logic       snap;
  logic [2:0] done;
  logic [7:0] ch_val [3];
  logic [23:0] target_bits;

  localparam logic [23:0] INIT_BITS = PALETTE[0];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= DWELL;
    else       state_reg <= state_next;
  end
`endif

  always_comb begin
    cnt_next  = cnt_reg;
    idx_next  = idx_reg;
    wrap_next = 1'b0;
    advance   = 1'b0;
    count_en  = 1'b1;
`ifdef COLOR_FADE_EN
    state_next = state_reg;
    fade_en    = 1'b0;
    snap       = 1'b0;
    unique case (state_reg)
      DWELL: begin
        advance = dwell_adv;
        if (dwell_adv) state_next = FADE;
      end
      FADE: begin
        count_en = 1'b0;
        if (step) begin
          snap       = 1'b1;
          state_next = DWELL;
        end else if (&done) begin
          // Leaving FADE is a state change, so it waits while paused.
          if (!pause) state_next = DWELL;
        end else begin
          fade_en = eff_tick;
        end
      end
      default: state_next = DWELL;
    endcase
`else
    advance = dwell_adv;
`endif
    if (advance) begin
      idx_next  = idx_reg + 3'd1;
      wrap_next = (idx_reg == LAST_IDX);
      cnt_next  = '0;
    end else if (count_en && eff_tick) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      idx_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      idx_reg  <= idx_next;
      wrap_reg <= wrap_next;
    end
  end

`ifdef COLOR_FADE_EN
  // idx_reg already points at the new color while fading toward it.
  assign target_bits = PALETTE[idx_reg];

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    color_fade_channel #(
      .INIT (INIT_BITS[23-8*gi -: 8]),
      .STEP (FADE_STEP)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .enable (fade_en),
      .snap   (snap),
      .target (target_bits[23-8*gi -: 8]),
      .value  (ch_val[gi]),
      .done   (done[gi])
    );
  end

  assign red   = ch_val[0];
  assign green = ch_val[1];
  assign blue  = ch_val[2];
`else
  rgb_t rgb_reg;

  always_ff @(posedge clk) begin
    if (reset)        rgb_reg <= PALETTE[0];
    else if (advance) rgb_reg <= PALETTE[idx_next];
  end

  assign red   = rgb_reg.r;
  assign green = rgb_reg.g;
  assign blue  = rgb_reg.b;
`endif

  assign color_idx = idx_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_color_sequencer.sv
// Self-checking bench for color_sequencer: directed scenarios plus random stimulus
// against a behavioural model. Honors COLOR_FADE_EN when defined.
module tb_color_sequencer;
  import color_pkg::*;

  localparam int T  = 3;
  localparam int FS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [7:0] red, green, blue;
  logic [2:0] color_idx;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  int m_idx;
  int m_cnt;
  int m_ch [3];
  bit m_wrap;
  bit m_fading;

  color_sequencer #(
    .TICKS_PER_COLOR (T),
    .FADE_STEP       (FS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .pause     (pause),
    .step      (step),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .color_idx (color_idx),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pal_ch(input int idx, input int c);
    logic [23:0] p;
    p = PALETTE[idx];
    return int'(p[23-8*c -: 8]);
  endfunction

  function automatic bit fade_on();
`ifdef COLOR_FADE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [23:0] model_rgb();
    return {m_ch[0][7:0], m_ch[1][7:0], m_ch[2][7:0]};
  endfunction

  // Behavioural model: palette walk with integer dwell count and signed channel arithmetic.
  task automatic model_step(input bit r, input bit t, input bit p, input bit s);
    bit eff;
    bit at_target;
    eff = t && !p;
    if (r) begin
      m_idx = 0; m_cnt = 0; m_wrap = 0; m_fading = 0;
      for (int c = 0; c < 3; c++) m_ch[c] = pal_ch(0, c);
      return;
    end
    m_wrap = 0;
    if (!m_fading) begin
      if (s || (eff && m_cnt == T - 1)) begin
        m_wrap = (m_idx == NUM_COLORS - 1);
        m_idx  = (m_idx + 1) % NUM_COLORS;
        m_cnt  = 0;
        if (fade_on()) m_fading = 1;
        else for (int c = 0; c < 3; c++) m_ch[c] = pal_ch(m_idx, c);
      end else if (eff) begin
        m_cnt++;
      end
    end else begin
      at_target = 1;
      for (int c = 0; c < 3; c++) if (m_ch[c] != pal_ch(m_idx, c)) at_target = 0;
      if (s) begin
        for (int c = 0; c < 3; c++) m_ch[c] = pal_ch(m_idx, c);
        m_fading = 0;
      end else if (at_target) begin
        if (!p) m_fading = 0;
      end else if (eff) begin
        for (int c = 0; c < 3; c++) begin
          int d;
          d = pal_ch(m_idx, c) - m_ch[c];
          if (d > 0)      m_ch[c] += (d < FS) ? d : FS;
          else if (d < 0) m_ch[c] -= (-d < FS) ? -d : FS;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit t, input bit p, input bit s);
    reset = r; tick = t; pause = p; step = s;
    @(posedge clk);
    model_step(r, t, p, s);
    #1;
    check("color_idx", 32'(color_idx), 32'(m_idx));
    check("rgb", 32'({red, green, blue}), 32'(model_rgb()));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    int wraps;
    logic [7:0] exp_r [4];
    logic [7:0] exp_g [4];

    // Reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("reset_idx", 32'(color_idx), 32'd0);
    check("reset_rgb", 32'({red, green, blue}), 32'h00FF0000);
    check("reset_wrap", 32'(wrap), 32'd0);
    $display("reset: idx=%0d rgb=%02h%02h%02h", color_idx, red, green, blue);

`ifndef COLOR_FADE_EN
    // Three ticks advance to color 1
    repeat (3) cycle(0, 1, 0, 0);
    check("adv_idx", 32'(color_idx), 32'd1);
    check("adv_rgb", 32'({red, green, blue}), 32'h0000FF00);
    $display("advance: idx=%0d rgb=%02h%02h%02h", color_idx, red, green, blue);

    // 24 ticks from reset give exactly one wrap pulse
    cycle(1, 0, 0, 0);
    wraps = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(0, 1, 0, 0);
      if (wrap) wraps++;
    end
    check("wrap_count", 32'(wraps), 32'd1);
    check("wrap_idx", 32'(color_idx), 32'd0);
    check("wrap_rgb", 32'({red, green, blue}), 32'h00FF0000);
    $display("wrap: pulses=%0d idx=%0d", wraps, color_idx);

    // Pause ignores ticks, step still advances
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 1, 1, 0);
    check("pause_idx", 32'(color_idx), 32'd0);
    cycle(0, 0, 1, 1);
    check("pause_step_idx", 32'(color_idx), 32'd1);
    $display("pause/step: idx=%0d", color_idx);

    // step with tick at terminal count: one advance, counter cleared
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    check("simul_idx", 32'(color_idx), 32'd1);
    repeat (2) cycle(0, 1, 0, 0);
    check("simul_hold_idx", 32'(color_idx), 32'd1);
    cycle(0, 1, 0, 0);
    check("simul_next_idx", 32'(color_idx), 32'd2);
    $display("simultaneous: idx=%0d", color_idx);
`else
    // Fade from color 0 to color 1 with FADE_STEP=64
    exp_r = '{8'hBF, 8'h7F, 8'h3F, 8'h00};
    exp_g = '{8'h40, 8'h80, 8'hC0, 8'hFF};
    cycle(0, 0, 0, 1);
    check("fade_start_idx", 32'(color_idx), 32'd1);
    check("fade_start_rgb", 32'({red, green, blue}), 32'h00FF0000);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0);
      check("fade_red", 32'(red), 32'(exp_r[i]));
      check("fade_green", 32'(green), 32'(exp_g[i]));
      check("fade_blue", 32'(blue), 32'd0);
    end
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    check("fade_dwell_idx", 32'(color_idx), 32'd2);
    $display("fade: idx=%0d rgb=%02h%02h%02h", color_idx, red, green, blue);

    // Reset in the middle of a fade
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("midfade_rst_idx", 32'(color_idx), 32'd0);
    check("midfade_rst_rgb", 32'({red, green, blue}), 32'h00FF0000);
    repeat (3) cycle(0, 1, 0, 0);
    check("midfade_dwell_idx", 32'(color_idx), 32'd1);
    $display("reset mid-fade: idx=%0d", color_idx);
`endif

    // Random stimulus against the model
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0);
    end
    $display("random: 3000 cycles done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
